// File: rtl/x_host_link_pkg.sv
// Shared types and constants for the host-side UART control link.
// Bit period helper clamps very fast baud settings to a usable minimum.
package x_host_link_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  localparam int c_bytes = 4;

  typedef logic [1:0] byte_idx_t;

  function automatic int bit_period(input int clk_hz, input int baud);
    int p;
    p = clk_hz / baud;
    return (p < 4) ? 4 : p;
  endfunction

endpackage

// File: rtl/x_host_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect,
// half-bit glitch re-check, mid-bit sampling, byte strobe with framing error.
module x_host_uart_rx
  import x_host_link_pkg::*;
#(
  parameter int p_bit = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_rx,
  output logic       o_start_det,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int c_half = p_bit / 2;
  localparam int c_cw   = $clog2(p_bit);

  logic            rx_meta_reg;
  logic            rx_sync_reg;
  logic            rx_prev_reg;
  logic            active_reg;
  logic [c_cw-1:0] tick_reg;
  logic [3:0]      bit_idx_reg;
  logic [7:0]      shift_reg;

  // Only a falling edge seen while hunting counts as a start bit.
  assign o_start_det = i_en & ~active_reg & rx_prev_reg & ~rx_sync_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      active_reg   <= 1'b0;
      tick_reg     <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      o_byte_valid <= 1'b0;
      o_byte_data  <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      rx_meta_reg  <= i_rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      o_byte_valid <= 1'b0;
      if (!i_en) begin
        active_reg <= 1'b0;
      end else if (o_start_det) begin
        active_reg  <= 1'b1;
        tick_reg    <= c_cw'(c_half - 1);
        bit_idx_reg <= '0;
      end else if (active_reg) begin
        if (tick_reg != '0) begin
          tick_reg <= tick_reg - 1'b1;
        end else begin
          tick_reg    <= c_cw'(p_bit - 1);
          bit_idx_reg <= bit_idx_reg + 1'b1;
          if (bit_idx_reg == 4'd0) begin
            if (rx_sync_reg) active_reg <= 1'b0;
          end else if (bit_idx_reg <= 4'd8) begin
            shift_reg <= {rx_sync_reg, shift_reg[7:1]};
          end else begin
            active_reg   <= 1'b0;
            o_byte_valid <= 1'b1;
            o_byte_data  <= shift_reg;
            o_frame_err  <= ~rx_sync_reg;
          end
        end
      end
    end
  end

endmodule

// File: rtl/x_host_link.sv
// Host side of the UART control link: sends a 32-bit request as four 8N1
// bytes (LSB byte first) and gathers the 4-byte reply into one response word.
module x_host_link
  import x_host_link_pkg::*;
#(
  parameter int p_clk_hz  = 96000000,
  parameter int p_baud    = 115200,
  parameter int p_timeout = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_data,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_timeout,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic        o_tx,
  input  logic        i_rx
);

  localparam int c_bit = bit_period(p_clk_hz, p_baud);
  localparam int c_cw  = $clog2(c_bit);
  localparam int c_tw  = $clog2(p_timeout + 1);

  state_t          state_reg;
  logic [31:0]     req_reg;
  logic [c_cw-1:0] tx_tick_reg;
  logic [3:0]      tx_bit_reg;
  byte_idx_t       tx_idx_reg;
  logic [c_tw-1:0] tmo_cnt_reg;
  logic [31:0]     rsp_buf_reg;
  logic [2:0]      rx_cnt_reg;
  logic            rx_err_reg;

  logic       rx_en;
  logic       rx_start;
  logic       rx_valid;
  logic       rx_ferr;
  logic [7:0] rx_byte;
  logic [7:0] tx_cur;
  logic [7:0] req_bytes [c_bytes];

  genvar gi;
  generate
    for (gi = 0; gi < c_bytes; gi++) begin : g_req_lane
      assign req_bytes[gi] = req_reg[8*gi +: 8];
    end
  endgenerate

  assign tx_cur = req_bytes[tx_idx_reg];

  // The receiver listens during SEND too, so a loopback echo is captured.
  assign rx_en = (state_reg == SEND) || (state_reg == WAIT);

  x_host_uart_rx #(
    .p_bit (c_bit)
  ) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (rx_en),
    .i_rx         (i_rx),
    .o_start_det  (rx_start),
    .o_byte_valid (rx_valid),
    .o_byte_data  (rx_byte),
    .o_frame_err  (rx_ferr)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      o_tx          <= 1'b1;
      o_req_ready   <= 1'b0;
      o_busy        <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_timeout <= 1'b0;
      o_rsp_err     <= 1'b0;
      req_reg       <= '0;
      tx_tick_reg   <= '0;
      tx_bit_reg    <= '0;
      tx_idx_reg    <= '0;
      tmo_cnt_reg   <= '0;
      rsp_buf_reg   <= '0;
      rx_cnt_reg    <= '0;
      rx_err_reg    <= 1'b0;
    end else begin
      if (rx_en && rx_valid && (rx_cnt_reg < 3'(c_bytes))) begin
        rsp_buf_reg[8*rx_cnt_reg[1:0] +: 8] <= rx_byte;
        rx_cnt_reg <= rx_cnt_reg + 1'b1;
        rx_err_reg <= rx_err_reg | rx_ferr;
      end
      case (state_reg)
        IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            state_reg   <= SEND;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            req_reg     <= i_req_data;
            o_tx        <= 1'b0;
            tx_tick_reg <= c_cw'(c_bit - 1);
            tx_bit_reg  <= '0;
            tx_idx_reg  <= '0;
            rsp_buf_reg <= '0;
            rx_cnt_reg  <= '0;
            rx_err_reg  <= 1'b0;
          end
        end
        SEND: begin
          if (tx_tick_reg != '0) begin
            tx_tick_reg <= tx_tick_reg - 1'b1;
          end else begin
            tx_tick_reg <= c_cw'(c_bit - 1);
            if (tx_bit_reg == 4'd9) begin
              if (tx_idx_reg == byte_idx_t'(c_bytes - 1)) begin
                state_reg   <= WAIT;
                tmo_cnt_reg <= '0;
              end else begin
                tx_idx_reg <= tx_idx_reg + 1'b1;
                tx_bit_reg <= '0;
                o_tx       <= 1'b0;
              end
            end else begin
              tx_bit_reg <= tx_bit_reg + 1'b1;
              o_tx       <= (tx_bit_reg == 4'd8) ? 1'b1 : tx_cur[tx_bit_reg[2:0]];
            end
          end
        end
        WAIT: begin
          // Timeout is checked first so it wins over a coincident start bit.
          if (tmo_cnt_reg == c_tw'(p_timeout)) begin
            state_reg     <= DONE;
            o_rsp_valid   <= 1'b1;
            o_rsp_data    <= rsp_buf_reg;
            o_rsp_timeout <= 1'b1;
            o_rsp_err     <= rx_err_reg;
          end else if (rx_cnt_reg == 3'(c_bytes)) begin
            state_reg     <= DONE;
            o_rsp_valid   <= 1'b1;
            o_rsp_data    <= rsp_buf_reg;
            o_rsp_timeout <= 1'b0;
            o_rsp_err     <= rx_err_reg;
          end else if (rx_start) begin
            tmo_cnt_reg <= '0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg   <= IDLE;
          o_rsp_valid <= 1'b0;
          o_busy      <= 1'b0;
          o_req_ready <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
